// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory requester: FSM states,
// memory-mapped device addresses and device register bit positions.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  localparam int READY_BIT  = 15;
  localparam int IE_BIT     = 14;
  localparam int CLK_EN_BIT = 15;

endpackage

// File: rtl/lc3_mem_requester_if.sv
// Bundle of control-unit, RAM, keyboard and display signals around the requester.
// master = the requester itself, slave = everything it talks to.
interface lc3_mem_requester_if;

  // Request/response handshake: a request transfers on a rising edge where
  // req_valid && req_ready; req_ready is high only while idle. The response
  // is a one-cycle rsp_valid strobe with no back-pressure; rsp_err qualifies it.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  logic        MEM_EN;
  logic        R_W;
  logic [15:0] a;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic        R;

  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack;
  logic        run;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, d_out, R,
           kb_valid, kb_data, disp_ack,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, MEM_EN, R_W, a, d_in,
           disp_valid, disp_data, run
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, d_out, R,
           kb_valid, kb_data, disp_ack,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, MEM_EN, R_W, a, d_in,
           disp_valid, disp_data, run
  );

endinterface

// File: rtl/lc3_mmio_regs.sv
// LC-3 device page: keyboard, display and machine-control registers with
// their handshakes. Accesses are applied on the edge where stb_i is high.
module lc3_mmio_regs
  import lc3_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        err_o,
  input  logic        kb_valid_i,
  input  logic [7:0]  kb_data_i,
  input  logic        disp_ack_i,
  output logic        disp_valid_o,
  output logic [7:0]  disp_data_o,
  output logic        run_o
);

  logic        kb_rdy_q;
  logic        kb_ie_q;
  logic [7:0]  kbdr_q;
  logic        dsr_rdy_q;
  logic        disp_valid_q;
  logic [7:0]  disp_data_q;
  logic [15:0] mcr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      kb_rdy_q     <= 1'b0;
      kb_ie_q      <= 1'b0;
      kbdr_q       <= 8'h00;
      dsr_rdy_q    <= 1'b1;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      mcr_q        <= 16'h8000;
    end else begin
      disp_valid_q <= 1'b0;
      if (stb_i && !we_i && addr_i == ADDR_KBDR) kb_rdy_q <= 1'b0;
      // A new character wins over a simultaneous KBDR read.
      if (kb_valid_i) begin
        kb_rdy_q <= 1'b1;
        kbdr_q   <= kb_data_i;
      end
      if (disp_ack_i) dsr_rdy_q <= 1'b1;
      if (stb_i && we_i) begin
        case (addr_i)
          ADDR_KBSR: kb_ie_q <= wdata_i[IE_BIT];
          ADDR_DDR: begin
            if (dsr_rdy_q) begin
              disp_data_q  <= wdata_i[7:0];
              disp_valid_q <= 1'b1;
              dsr_rdy_q    <= 1'b0;
            end
          end
          ADDR_MCR:  mcr_q <= wdata_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_o = 16'h0000;
    err_o   = 1'b0;
    case (addr_i)
      ADDR_KBSR: begin
        rdata_o[READY_BIT] = kb_rdy_q;
        rdata_o[IE_BIT]    = kb_ie_q;
      end
      ADDR_KBDR: rdata_o = {8'h00, kbdr_q};
      ADDR_DSR:  rdata_o[READY_BIT] = dsr_rdy_q;
      ADDR_DDR:  rdata_o = 16'h0000;
      ADDR_MCR:  rdata_o = mcr_q;
      default:   err_o = 1'b1;
    endcase
  end

  assign disp_valid_o = disp_valid_q;
  assign disp_data_o  = disp_data_q;
  assign run_o        = mcr_q[CLK_EN_BIT];

endmodule

// File: rtl/lc3_mem_requester.sv
// LC-3 memory-port initiator: serves control-unit loads/stores from the
// single-port RAM (with timeout) or from the local device page.
module lc3_mem_requester
  import lc3_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [15:0] MMIO_BASE      = 16'hFE00
) (
  input  logic                 clk,
  input  logic                 reset,
  lc3_mem_requester_if.master  bus,
  output state_t               state_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_en_q, mem_en_d;
  logic        r_w_q, r_w_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_in_q, d_in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic        is_dev;
  logic        dev_stb;
  logic [15:0] mmio_rdata;
  logic        mmio_err;

  assign accept  = (state_q == ST_IDLE) && bus.req_valid;
  assign is_dev  = bus.req_addr >= MMIO_BASE;
  assign dev_stb = accept && is_dev;

  lc3_mmio_regs u_mmio (
    .clk          (clk),
    .reset        (reset),
    .stb_i        (dev_stb),
    .we_i         (bus.req_we),
    .addr_i       (bus.req_addr),
    .wdata_i      (bus.req_wdata),
    .rdata_o      (mmio_rdata),
    .err_o        (mmio_err),
    .kb_valid_i   (bus.kb_valid),
    .kb_data_i    (bus.kb_data),
    .disp_ack_i   (bus.disp_ack),
    .disp_valid_o (bus.disp_valid),
    .disp_data_o  (bus.disp_data),
    .run_o        (bus.run)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 16'h0000;
      req_ready_q <= 1'b1;
      mem_en_q    <= 1'b0;
      r_w_q       <= 1'b0;
      a_q         <= 16'h0000;
      d_in_q      <= 16'h0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      mem_en_q    <= mem_en_d;
      r_w_q       <= r_w_d;
      a_q         <= a_d;
      d_in_q      <= d_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = is_dev ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.R || cnt_q == TO_LAST) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are loaded one edge early so they are valid during
  // the state they belong to (MEM_EN during ISSUE, rsp_valid during RESP).
  always_comb begin
    cnt_d       = cnt_q;
    req_ready_d = (state_d == ST_IDLE);
    mem_en_d    = 1'b0;
    r_w_d       = r_w_q;
    a_d         = a_q;
    d_in_d      = d_in_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_dev) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = mmio_err;
            rsp_rdata_d = bus.req_we ? 16'h0000 : mmio_rdata;
          end else begin
            mem_en_d = 1'b1;
            r_w_d    = bus.req_we;
            a_d      = bus.req_addr;
            d_in_d   = bus.req_wdata;
          end
        end
      end
      ST_ISSUE: cnt_d = 16'h0000;
      ST_WAIT: begin
        if (bus.R) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = r_w_q ? 16'h0000 : bus.d_out;
        end else if (cnt_q == TO_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 16'h0000;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.MEM_EN    = mem_en_q;
  assign bus.R_W       = r_w_q;
  assign bus.a         = a_q;
  assign bus.d_in      = d_in_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_lc3_mem_requester.sv
// Directed bench for lc3_mem_requester: RAM responder model, device-page
// accesses, and a scoreboard checking every response strobe.
module tb_lc3_mem_requester;
  import lc3_mem_pkg::*;

  localparam int TO = 4;
  localparam int W  = 25; // {latency[7:0], err, rdata[15:0]}

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t state;

  lc3_mem_requester_if bus ();

  lc3_mem_requester #(.TIMEOUT_CYCLES(TO), .MMIO_BASE(16'hFE00)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.master),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rsp_seen = 0;
  int rsp_pushed = 0;
  int mem_en_cnt = 0;
  int disp_cnt = 0;
  logic [7:0]  disp_last = 8'h00;
  logic [15:0] last_a = 16'h0, last_d = 16'h0;
  logic        last_rw = 1'b0;
  logic        ram_mute = 1'b0;
  logic        ram_r = 1'b0, late_r = 1'b0;
  logic [15:0] ram_dout = 16'h0;
  logic [15:0] ram [0:65535];
  logic [W-1:0] exp_q[$];

  assign bus.R     = ram_r | late_r;
  assign bus.d_out = ram_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // RAM responder: sees MEM_EN during ISSUE, answers with R in the first WAIT cycle.
  always begin
    @(negedge clk);
    if (bus.MEM_EN) begin
      mem_en_cnt++;
      last_a  = bus.a;
      last_rw = bus.R_W;
      last_d  = bus.d_in;
      if (last_rw) ram[last_a] = last_d;
      if (!ram_mute) begin
        @(posedge clk); #1;
        ram_dout = last_rw ? 16'h0000 : ram[last_a];
        ram_r = 1'b1;
        @(posedge clk); #1;
        ram_r = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every response strobe.
  always @(negedge clk) begin
    logic [W-1:0] item;
    if (bus.req_valid && bus.req_ready && !reset) acc_cyc = cyc;
    if (bus.disp_valid) begin
      disp_cnt++;
      disp_last = bus.disp_data;
    end
    if (bus.rsp_valid) begin
      rsp_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_seen), 32'(rsp_pushed));
      end else begin
        item = exp_q.pop_front();
        chk("rsp_err",   32'(bus.rsp_err),   32'(item[16]));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(item[15:0]));
        chk("rsp_lat",   32'(cyc - acc_cyc), 32'(item[24:17]));
      end
    end
  end

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic err, input logic [15:0] rdata, input logic [7:0] lat,
                        input logic kb_same, input logic [7:0] kb_byte);
    int n = 0;
    exp_q.push_back({lat, err, rdata});
    rsp_pushed++;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    if (kb_same) begin
      bus.kb_valid = 1'b1;
      bus.kb_data  = kb_byte;
    end
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.kb_valid  = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic dev_rd(input logic [15:0] addr, input logic [15:0] exp);
    do_req(1'b0, addr, 16'h0, 1'b0, exp, 8'd1, 1'b0, 8'h00);
  endtask

  task automatic dev_wr(input logic [15:0] addr, input logic [15:0] data);
    do_req(1'b1, addr, data, 1'b0, 16'h0, 8'd1, 1'b0, 8'h00);
  endtask

  task automatic pulse_cycle(output logic sig);
    sig = 1'b0;
  endtask

  initial begin
    int m0, d0, n;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 16'h0;
    bus.kb_valid = 1'b0; bus.kb_data = 8'h00; bus.disp_ack = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
    ram[16'h3000] = 16'h1234;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_state",   32'(state),          32'(ST_IDLE));
    chk("rst_ready",   32'(bus.req_ready),  32'd1);
    chk("rst_mem_en",  32'(bus.MEM_EN),     32'd0);
    chk("rst_rsp",     32'(bus.rsp_valid),  32'd0);
    chk("rst_a",       32'(bus.a),          32'd0);
    chk("rst_disp",    32'(bus.disp_valid), 32'd0);
    chk("rst_run",     32'(bus.run),        32'd1);

    // RAM load, store, load-back: accept edge to response strobe = 3 edges.
    m0 = mem_en_cnt;
    do_req(1'b0, 16'h3000, 16'h0, 1'b0, 16'h1234, 8'd3, 1'b0, 8'h00);
    chk("ld_mem_en_cnt", 32'(mem_en_cnt - m0), 32'd1);
    chk("ld_rw", 32'(last_rw), 32'd0);
    chk("ld_a",  32'(last_a),  32'h3000);
    m0 = mem_en_cnt;
    do_req(1'b1, 16'h4000, 16'hBEEF, 1'b0, 16'h0000, 8'd3, 1'b0, 8'h00);
    chk("st_mem_en_cnt", 32'(mem_en_cnt - m0), 32'd1);
    chk("st_rw",   32'(last_rw), 32'd1);
    chk("st_d_in", 32'(last_d),  32'hBEEF);
    do_req(1'b0, 16'h4000, 16'h0, 1'b0, 16'hBEEF, 8'd3, 1'b0, 8'h00);

    // Timeout: ISSUE ends on the edge after acceptance, the error strobe is
    // raised TO edges after that, so TO+2 edges after acceptance.
    ram_mute = 1'b1;
    m0 = mem_en_cnt;
    do_req(1'b0, 16'h5000, 16'h0, 1'b1, 16'h0000, 8'(TO + 2), 1'b0, 8'h00);
    chk("to_mem_en_cnt", 32'(mem_en_cnt - m0), 32'd1);
    ram_mute = 1'b0;
    @(posedge clk); #1 late_r = 1'b1;
    @(posedge clk); #1 late_r = 1'b0;
    repeat (6) @(negedge clk);
    chk("late_r_state", 32'(state), 32'(ST_IDLE));
    chk("late_r_rsp_count", 32'(rsp_seen), 32'(rsp_pushed));

    // Keyboard.
    @(posedge clk); #1 bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
    @(posedge clk); #1 bus.kb_valid = 1'b0;
    m0 = mem_en_cnt;
    dev_rd(ADDR_KBSR, 16'h8000);
    dev_rd(ADDR_KBDR, 16'h0041);
    dev_rd(ADDR_KBSR, 16'h0000);
    do_req(1'b0, ADDR_KBDR, 16'h0, 1'b0, 16'h0041, 8'd1, 1'b1, 8'h42);
    dev_rd(ADDR_KBSR, 16'h8000);
    dev_wr(ADDR_KBDR, 16'h00FF);
    dev_rd(ADDR_KBDR, 16'h0042);
    dev_wr(ADDR_KBSR, 16'hFFFF);
    dev_rd(ADDR_KBSR, 16'h4000);
    chk("kb_mem_en_cnt", 32'(mem_en_cnt - m0), 32'd0);

    // Display.
    d0 = disp_cnt;
    dev_wr(ADDR_DDR, 16'h0058);
    chk("disp_cnt1", 32'(disp_cnt - d0), 32'd1);
    chk("disp_data", 32'(disp_last), 32'h58);
    dev_rd(ADDR_DSR, 16'h0000);
    dev_wr(ADDR_DDR, 16'h0059);
    chk("disp_cnt_dropped", 32'(disp_cnt - d0), 32'd1);
    @(posedge clk); #1 bus.disp_ack = 1'b1;
    @(posedge clk); #1 bus.disp_ack = 1'b0;
    dev_rd(ADDR_DSR, 16'h8000);
    dev_rd(ADDR_DDR, 16'h0000);

    // Unmapped device-page addresses.
    do_req(1'b0, 16'hFE08, 16'h0, 1'b1, 16'h0000, 8'd1, 1'b0, 8'h00);
    do_req(1'b1, 16'hFF00, 16'h1111, 1'b1, 16'h0000, 8'd1, 1'b0, 8'h00);

    // Machine control: run drops but requests are still served.
    m0 = mem_en_cnt;
    dev_wr(ADDR_MCR, 16'h0000);
    @(negedge clk);
    chk("mcr_run0", 32'(bus.run), 32'd0);
    dev_rd(ADDR_MCR, 16'h0000);
    chk("mcr_mem_en_cnt", 32'(mem_en_cnt - m0), 32'd0);
    do_req(1'b0, 16'h3000, 16'h0, 1'b0, 16'h1234, 8'd3, 1'b0, 8'h00);

    // Reset during WAIT: no response, device registers back to reset values.
    ram_mute = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 16'h6000;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    n = 0;
    while (state != ST_WAIT && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_wait", 32'(state), 32'(ST_WAIT));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_state",  32'(state),         32'(ST_IDLE));
    chk("midrst_mem_en", 32'(bus.MEM_EN),    32'd0);
    chk("midrst_rsp",    32'(bus.rsp_valid), 32'd0);
    chk("midrst_run",    32'(bus.run),       32'd1);
    ram_mute = 1'b0;
    repeat (6) @(negedge clk);
    dev_rd(ADDR_MCR, 16'h8000);
    dev_rd(ADDR_DSR, 16'h8000);

    chk("final_rsp_count", 32'(rsp_seen), 32'(rsp_pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by %0t expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lc3_mem_requester.md
Name: lc3_mem_requester

Overview:
- Memory-port initiator for the LC-3 datapath.
- Accepts load/store requests from the control unit (MAR/MDR side) over a valid/ready handshake.
- Drives the single-port RAM responder's MEM_EN/R_W/a/d_in pins, waits for its R completion flag, and returns read data or a timeout error.
- Decodes the LC-3 memory-mapped device registers (KBSR, KBDR, DSR, DDR, MCR) locally; those accesses never reach RAM.

Parameters:
- TIMEOUT_CYCLES, 16, cycles waited in WAIT for R before the access is flagged as an error (minimum 1).
- MMIO_BASE, 16'hFE00, base address of the device page; addresses >= MMIO_BASE are never sent to RAM.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  control unit presents a request.
- req_ready  out  1  requester can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  16  word address (MAR).
- req_wdata  in  16  store data (MDR).
- rsp_valid  out  1  single-cycle response strobe.
- rsp_rdata  out  16  load data; 0 for stores.
- rsp_err  out  1  qualifies rsp_valid; RAM timeout or unmapped device-page access.
- MEM_EN  out  1  RAM enable.
- R_W  out  1  RAM direction, 1 = write.
- a  out  16  RAM address.
- d_in  out  16  RAM write data.
- d_out  in  16  RAM read data.
- R  in  1  RAM completion flag.
- kb_valid  in  1  keyboard character strobe.
- kb_data  in  8  keyboard character.
- disp_valid  out  1  display character strobe (one cycle).
- disp_data  out  8  display character.
- disp_ack  in  1  display finished the last character.
- run  out  1  MCR[15], machine clock enable.

Behaviour:
- Reset values:
  - State IDLE; MEM_EN, R_W, rsp_valid, rsp_err, disp_valid = 0.
  - a, d_in, rsp_rdata, disp_data = 0.
  - KBSR = 0, KBDR = 0, DSR[15] = 1, MCR = 16'h8000, so run = 1.
  - Wait counter = 0.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready = 1. On req_valid, capture we/addr/wdata.
  - If addr >= MMIO_BASE: perform the device access this edge and go to RESP.
  - Otherwise go to ISSUE.
- ISSUE:
  - MEM_EN = 1 for exactly one cycle; a = addr, R_W = we, d_in = wdata.
  - Next state WAIT; counter cleared.
- WAIT:
  - MEM_EN = 0. R is sampled only in this state.
  - R = 1: rsp_rdata <= (we ? 0 : d_out), go to RESP.
  - Otherwise increment the counter. At TIMEOUT_CYCLES: rsp_err <= 1, rsp_rdata <= 0, go to RESP.
- RESP: rsp_valid = 1 for one cycle, then IDLE. rsp_err is cleared on leaving RESP.
- RAM latency: request accepted at edge E0 gives rsp_valid high in the cycle after E2, i.e. 3 cycles, with the RAM answering on the first WAIT cycle. Device access: rsp_valid in the cycle after acceptance.
- Device registers:
  - KBSR FE00, KBDR FE02, DSR FE04, DDR FE06, MCR FFFE. Any other device-page address gives rsp_err = 1 with read data 0.
  - KBSR: kb_valid sets bit 15 and latches KBDR = {8'h00, kb_data}. A read of KBDR clears bit 15. kb_valid and a KBDR read in the same cycle leave bit 15 = 1 with the new data. kb_valid while bit 15 = 1 overwrites KBDR. Bit 14 (IE) is writable; all other bits read 0.
  - DDR write while DSR[15] = 1: disp_data = wdata[7:0], disp_valid pulses for one cycle, DSR[15] cleared. DDR write while DSR[15] = 0 is dropped, no error. disp_ack sets DSR[15].
  - DSR and KBDR are read-only; writes to them are ignored. DDR reads return 0.
  - MCR: fully writable. run = MCR[15]; requests are still served when run = 0.
- Late R: an R arriving outside WAIT is ignored.
- Reset mid-access: returns to IDLE, drops MEM_EN, and produces no response.

Decomposition:
- Package lc3_mem_pkg:
  - FSM state enum.
  - Device address constants ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR, ADDR_MCR.
  - Bit positions READY_BIT = 15, IE_BIT = 14, CLK_EN_BIT = 15.
- One sub-module, lc3_mmio_regs: KBSR/KBDR/DSR/DDR/MCR storage, kb/display handshakes, and read mux. The FSM drives it with a one-cycle access strobe plus we/addr/wdata.

Test Plan:
- Load from RAM:
  - Stimulus: preload RAM[3000] = 16'h1234; request load of 3000.
  - Required: exactly one MEM_EN cycle with R_W = 0 and a = 3000; rsp_valid 3 cycles after acceptance; rsp_rdata = 1234; rsp_err = 0.
- Store then load:
  - Stimulus: store 16'hBEEF to 4000, then load 4000.
  - Required: one MEM_EN cycle with R_W = 1 and d_in = BEEF; the store response has rdata 0; the load returns BEEF.
- Timeout:
  - Stimulus: hold R = 0 with TIMEOUT_CYCLES = 4.
  - Required: rsp_valid with rsp_err = 1 and rdata 0, 4 cycles after the ISSUE cycle.
  - Stimulus: a late R pulse afterwards.
  - Required: no second rsp_valid.
- Keyboard:
  - Stimulus: kb_valid with 8'h41.
  - Required: KBSR reads 8000, then KBDR reads 0041, then KBSR reads 0000.
  - Stimulus: kb_valid in the same cycle as the KBDR read.
  - Required: KBSR stays 8000.
- Display:
  - Stimulus: write DDR = 0x0058.
  - Required: disp_valid pulse with disp_data 58; DSR reads 0000; a second DDR write gives no disp_valid; after disp_ack, DSR reads 8000.
- Machine control and reset:
  - Stimulus: write MCR = 0.
  - Required: run = 0, MEM_EN never asserted for the access.
  - Stimulus: reset asserted during WAIT.
  - Required: IDLE next cycle, no rsp_valid, MCR = 8000, run = 1.
